// File: rtl/vecfifo_wr_arbiter_if.sv
// Handshake bundle between NumReq vector producers, the write arbiter and one VecFIFO write port.
// The arbiter side uses the slave modport; producers and the FIFO consumer use master.
interface vecfifo_wr_arbiter_if #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned VecElements = 4
);
  logic [NumReq-1:0]                    req_valid_in;
  logic [NumReq-1:0]                    req_last_in;
  logic [NumReq-1:0][VecElements*8-1:0] req_data_in;
  logic [NumReq-1:0]                    req_ready_out;
  logic                                 fifo_wr_en_out;
  logic [VecElements*8-1:0]             fifo_wr_data_out;
  logic                                 fifo_rd_en_in;

  modport master (
    output req_valid_in, req_last_in, req_data_in, fifo_rd_en_in,
    input  req_ready_out, fifo_wr_en_out, fifo_wr_data_out
  );

  modport slave (
    input  req_valid_in, req_last_in, req_data_in, fifo_rd_en_in,
    output req_ready_out, fifo_wr_en_out, fifo_wr_data_out
  );
endinterface

// File: rtl/vecfifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one VecFIFO write port, with credit-based overflow protection.
// Optional per-producer accepted-beat counters: define VECFIFO_ARB_STATS_EN.
module vecfifo_wr_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned VecElements = 4,
  parameter int unsigned FifoDepth   = 8,
  parameter int unsigned BurstLen    = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  vecfifo_wr_arbiter_if.slave            bus,
  output logic [NumReq-1:0]              grant_out,
  output logic [$clog2(FifoDepth+1)-1:0] credit_out,
  output logic                           busy_out,
  output logic [NumReq-1:0][15:0]        stat_beats_out
);
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned BeatW = $clog2(BurstLen + 1);
  localparam int unsigned CredW = $clog2(FifoDepth + 1);
  localparam int unsigned DataW = VecElements * 8;

  localparam logic [BeatW-1:0] BeatMax = BeatW'(BurstLen);
  localparam logic [CredW-1:0] CredMax = CredW'(FifoDepth);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NumReq - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IdxW-1:0]  gnt_idx_q, gnt_idx_d;
  logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CredW-1:0] credit_q, credit_d;
  logic             wr_en_q;
  logic [DataW-1:0] wr_data_q;

  logic              in_burst, has_credit, accept, sel_valid, sel_last, pick_found;
  logic [IdxW-1:0]   pick_idx;
  logic [NumReq-1:0] gnt_onehot;

  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int unsigned off);
    return IdxW'((32'(base) + off) % NumReq);
  endfunction

  // gnt_idx_q doubles as the last-grant pointer: it is only rewritten when a new grant is made.
  assign in_burst   = (state_q == StBurst);
  assign has_credit = (credit_q != '0);
  assign gnt_onehot = NumReq'(1) << gnt_idx_q;
  assign sel_valid  = bus.req_valid_in[gnt_idx_q];
  assign sel_last   = bus.req_last_in[gnt_idx_q];
  assign accept     = in_burst && has_credit && sel_valid;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      if (!pick_found && bus.req_valid_in[rr_idx(gnt_idx_q, off)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx(gnt_idx_q, off);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_found && has_credit) begin
          state_d    = StBurst;
          gnt_idx_d  = pick_idx;
          beat_cnt_d = '0;
        end
      end
      StBurst: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + BeatW'(1);
          if (sel_last || (beat_cnt_q + BeatW'(1) == BeatMax)) begin
            state_d = StIdle;
          end
        end else if (has_credit && !sel_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A read at full credit is dropped unless an accept in the same cycle makes room for it.
  always_comb begin
    credit_d = credit_q;
    if (accept && !bus.fifo_rd_en_in) begin
      credit_d = credit_q - CredW'(1);
    end else if (!accept && bus.fifo_rd_en_in && (credit_q != CredMax)) begin
      credit_d = credit_q + CredW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      gnt_idx_q  <= LastIdx;
      beat_cnt_q <= '0;
      credit_q   <= CredMax;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      beat_cnt_q <= beat_cnt_d;
      credit_q   <= credit_d;
      wr_en_q    <= accept;
      if (accept) begin
        wr_data_q <= bus.req_data_in[gnt_idx_q];
      end
    end
  end

  assign busy_out             = in_burst;
  assign grant_out            = in_burst ? gnt_onehot : '0;
  assign bus.req_ready_out    = (in_burst && has_credit) ? gnt_onehot : '0;
  assign bus.fifo_wr_en_out   = wr_en_q;
  assign bus.fifo_wr_data_out = wr_data_q;
  assign credit_out           = credit_q;

`ifdef VECFIFO_ARB_STATS_EN
  logic [NumReq-1:0][15:0] stat_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stat_q <= '0;
    end else if (accept && (stat_q[gnt_idx_q] != 16'hFFFF)) begin
      stat_q[gnt_idx_q] <= stat_q[gnt_idx_q] + 16'd1;
    end
  end

  assign stat_beats_out = stat_q;
`else
  assign stat_beats_out = '0;
`endif

  rd_at_full_credit_a: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(bus.fifo_rd_en_in && (credit_q == CredMax)));

endmodule
